// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: XLEN, NOP_INSTR, FSM state encoding, buffered {pc, instr} entry type.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// Latency: n/a (wires only).
// Backpressure: imem_ready throttles requests; dec_ready throttles the decode handshake.
// Modports: master = fetch unit (drives imem_req/addr, dec_*), slave = memory/execute/decode side.
interface fetch_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            dec_valid;
   logic [XLEN-1:0] dec_instr;
   logic [XLEN-1:0] dec_pc;
   logic            dec_ready;

   modport master (
      output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
      input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
      output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with a whole-buffer flush.
// Latency: a pushed entry appears on head_dat the cycle after the push (no bypass).
// Backpressure: a push into a full FIFO is accepted only alongside a pop; flush beats push and pop.
// Ports: clk/rst, flush, push/push_dat, pop, head_dat (valid when count != 0), count.
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_dat,
   input  logic                     pop,
   output fetch_entry_t             head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign do_pop  = pop & (cnt_q != '0);
   assign do_push = push & ((cnt_q != FULL) | do_pop);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_dat;
            wr_d        = wr_q + 1'b1;
         end
         if (do_pop) rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_dat = mem_q[rd_q];
   assign count    = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order imem requests, buffers {pc, instr} for decode.
// Latency: with a 1-cycle memory, request in cycle N -> dec_valid in N+2; steady state one instruction per cycle.
// Backpressure: requests stop once in-flight plus buffered entries would exceed FIFO_DEPTH; dec_ready pops the head.
// Ports: clk, rst (async, active-high), bus (fetch_if.master); with FETCH_PERF_EN defined, also
//        perf_fetched / perf_redirects (32-bit wrapping counts of pops and redirects).
module fetch_unit import fetch_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   fetch_if.master   bus
`ifdef FETCH_PERF_EN
   ,
   output logic [XLEN-1:0] perf_fetched,
   output logic [XLEN-1:0] perf_redirects
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] OCC_MAX = (CW+1)'(FIFO_DEPTH);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pcq_q [FIFO_DEPTH];
   logic [XLEN-1:0] pcq_d [FIFO_DEPTH];
   logic [AW-1:0]   pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   fifo_cnt;
   logic [CW:0]     occ;
   fetch_entry_t    fifo_head, fifo_wdat;
   logic            redir, dec_vld, pop, resp, drop, keep, req, issue, fifo_push;

   assign redir   = bus.redirect_valid;
   assign dec_vld = (fifo_cnt != '0);
   assign pop     = dec_vld & bus.dec_ready & ~redir;
   // A response with nothing outstanding is a protocol error and is ignored outright.
   assign resp    = bus.imem_rvalid & (outstanding_q != '0);
   assign drop    = resp & (drop_cnt_q != '0);
   assign keep    = resp & ~drop;
   // The slot freed by this cycle's pop counts as credit, so a 1-cycle memory sustains one fetch per cycle.
   assign occ     = {1'b0, outstanding_q} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
   assign req     = (state_q == RUN) & ~redir & (occ < OCC_MAX);
   assign issue   = req & bus.imem_ready;
   assign fifo_push = keep & ~redir;
   assign fifo_wdat = {pcq_q[pcq_rd_q], bus.imem_rdata};

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pcq_d         = pcq_q;
      pcq_wr_d      = pcq_wr_q;
      pcq_rd_d      = pcq_rd_q;
      outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
      drop_cnt_d    = drop_cnt_q;

      if (issue) begin
         pcq_d[pcq_wr_q] = pc_q;
         pcq_wr_d        = pcq_wr_q + 1'b1;
         pc_d            = pc_q + XLEN'(4);
      end
      if (keep) pcq_rd_d = pcq_rd_q + 1'b1;
      if (drop) drop_cnt_d = drop_cnt_q - 1'b1;

      // Every request still in flight after this cycle belongs to the old path and must be discarded.
      if (redir) begin
         pc_d       = bus.redirect_pc & ~XLEN'(3);
         pcq_rd_d   = pcq_wr_d;
         drop_cnt_d = outstanding_d;
      end

      unique case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (redir && drop_cnt_d != '0) state_d = FLUSH;
         FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         pcq_q         <= '{default: '0};
         pcq_wr_q      <= '0;
         pcq_rd_q      <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pcq_q         <= pcq_d;
         pcq_wr_q      <= pcq_wr_d;
         pcq_rd_q      <= pcq_rd_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redir),
      .push     (fifo_push),
      .push_dat (fifo_wdat),
      .pop      (pop),
      .head_dat (fifo_head),
      .count    (fifo_cnt)
   );

   assign bus.imem_req  = req;
   assign bus.imem_addr = pc_q;
   assign bus.dec_valid = dec_vld;
   assign bus.dec_pc    = dec_vld ? fifo_head.pc : '0;
   assign bus.dec_instr = dec_vld ? fifo_head.instr : NOP_INSTR;

`ifdef FETCH_PERF_EN
   logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
   logic [XLEN-1:0] perf_redirects_q, perf_redirects_d;

   always_comb begin
      perf_fetched_d   = perf_fetched_q + XLEN'(pop);
      perf_redirects_d = perf_redirects_q + XLEN'(redir);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q   <= '0;
         perf_redirects_q <= '0;
      end else begin
         perf_fetched_q   <= perf_fetched_d;
         perf_redirects_q <= perf_redirects_d;
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_redirects = perf_redirects_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory with random latency, random decode stalls and redirects,
// checked every cycle against a queue-based model of requests in flight and buffered instructions.
// Directed phases pin reset values, first-fetch latency, stall credit, redirect flushing, PC wrap and async reset.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_if bus ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_redirects;
`endif

   fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_redirects (perf_redirects)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } req_t;

   req_t        mq[$];     // requests accepted by memory, oldest first
   logic [31:0] dbuf[$];   // PCs of instructions the decode side must see, oldest first
   logic [31:0] exp_fetch;
   int          epoch = 0;
   int          cyc = 0;
   int          pops = 0;
   int          redirs = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          total = 0;
   int          bad = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle_inputs();
      bus.imem_ready     = 1'b1;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.dec_ready      = 1'b0;
   endtask

   // One clock cycle: drive inputs at the falling edge, check outputs 1 unit later, advance the model
   // to the state it must hold after the next rising edge.
   task automatic step(input logic rdy, input logic drdy, input logic redir,
                       input logic [31:0] rpc, input logic junk);
      logic resp, live, pop_e, stale_any, exp_req;
      int   occ;
      req_t r;
      @(negedge clk);
      resp = (mq.size() > 0) && (mq[0].due <= cyc);
      bus.imem_rvalid    = resp | (junk && mq.size() == 0);
      bus.imem_rdata     = resp ? mem_word(mq[0].addr) : $urandom;
      bus.imem_ready     = rdy;
      bus.dec_ready      = drdy;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      #1;
      chk("dec_valid", bus.dec_valid, dbuf.size() > 0);
      if (dbuf.size() > 0) begin
         chk("dec_pc", bus.dec_pc, dbuf[0]);
         chk("dec_instr", bus.dec_instr, mem_word(dbuf[0]));
      end else begin
         chk("dec_pc_idle", bus.dec_pc, 32'h0);
         chk("dec_instr_idle", bus.dec_instr, NOP_INSTR);
      end
      pop_e = (dbuf.size() > 0) && drdy && !redir;
      stale_any = 1'b0;
      foreach (mq[i]) if (mq[i].epoch != epoch) stale_any = 1'b1;
      occ = mq.size() + dbuf.size() - (pop_e ? 1 : 0);
      exp_req = !stale_any && !redir && (occ < DEPTH);
      chk("imem_req", bus.imem_req, exp_req);
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, exp_fetch);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, pops);
      chk("perf_redirects", perf_redirects, redirs);
`endif
      if (pop_e) begin
         void'(dbuf.pop_front());
         pops++;
      end
      if (resp) begin
         live = (mq[0].epoch == epoch) && !redir;
         if (live) dbuf.push_back(mq[0].addr);
         void'(mq.pop_front());
      end
      if (bus.imem_req && rdy) begin
         r.addr  = bus.imem_addr;
         r.due   = cyc + $urandom_range(lat_max, lat_min);
         r.epoch = epoch;
         mq.push_back(r);
         exp_fetch = exp_fetch + 32'd4;
      end
      if (redir) begin
         dbuf.delete();
         exp_fetch = rpc & ~32'd3;
         epoch++;
         redirs++;
      end
      cyc++;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, bus.imem_req, 1'b0);
      chk({tag, "_dec_valid"}, bus.dec_valid, 1'b0);
      chk({tag, "_dec_instr"}, bus.dec_instr, NOP_INSTR);
      chk({tag, "_dec_pc"}, bus.dec_pc, 32'h0);
`ifdef FETCH_PERF_EN
      chk({tag, "_perf_fetched"}, perf_fetched, 32'h0);
      chk({tag, "_perf_redirects"}, perf_redirects, 32'h0);
`endif
   endtask

   // Leaves the DUT in its IDLE cycle; the next step() is the first RUN cycle.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mq.delete();
      dbuf.delete();
      exp_fetch = RPC;
      pops = 0;
      redirs = 0;
      epoch++;
      #1;
      check_reset_outputs("reset");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic        rdy, drdy, redir, junk;
      logic [31:0] rpc;
      idle_inputs();

      // Startup trace with a 1-cycle memory.
      lat_min = 1; lat_max = 1;
      do_reset();
      step(1, 1, 0, 0, 0);
      chk("t1_req_c1", bus.imem_req, 1'b1);
      chk("t1_addr_c1", bus.imem_addr, 32'h0);
      step(1, 1, 0, 0, 0);
      chk("t1_addr_c2", bus.imem_addr, 32'h4);
      chk("t1_dv_c2", bus.dec_valid, 1'b0);
      step(1, 1, 0, 0, 0);
      chk("t1_addr_c3", bus.imem_addr, 32'h8);
      chk("t1_dv_c3", bus.dec_valid, 1'b1);
      chk("t1_pc_c3", bus.dec_pc, 32'h0);
      step(1, 1, 0, 0, 0);
      chk("t1_pc_c4", bus.dec_pc, 32'h4);
      step(1, 1, 0, 0, 0);
      chk("t1_pc_c5", bus.dec_pc, 32'h8);

      // Decode stalled: only FIFO_DEPTH requests may go out.
      do_reset();
      n = 0;
      for (int k = 0; k < 5; k++) begin
         step(1, 0, 0, 0, 0);
         if (bus.imem_req) n++;
      end
      chk("t2_issues", n, 2);
      chk("t2_req_off", bus.imem_req, 1'b0);
      step(1, 1, 0, 0, 0);
      chk("t2_resume_pc", bus.dec_pc, 32'h0);
      for (int k = 0; k < 12; k++) step(1, 1, 0, 0, 0);

      // Redirect with two requests in flight.
      lat_min = 3; lat_max = 3;
      do_reset();
      n = 0;
      do begin step(1, 1, 0, 0, 0); n++; end while (mq.size() < 2 && n < 10);
      step(1, 1, 1, 32'h0000_0103, 0);
      chk("t3_req_at_redir", bus.imem_req, 1'b0);
      n = 0;
      do begin step(1, 1, 0, 0, 0); n++; end while (!bus.imem_req && n < 10);
      chk("t3_req", bus.imem_req, 1'b1);
      chk("t3_addr", bus.imem_addr, 32'h0000_0100);
      chk("t3_flush_cycles", n, 3);
      n = 0;
      do begin step(1, 1, 0, 0, 0); n++; end while (!bus.dec_valid && n < 10);
      chk("t3_dv", bus.dec_valid, 1'b1);
      chk("t3_first_pc", bus.dec_pc, 32'h0000_0100);

      // Redirect in the same cycle as a response and a pop.
      lat_min = 1; lat_max = 1;
      do_reset();
      repeat (5) step(1, 1, 0, 0, 0);
      step(1, 1, 1, 32'h0000_2002, 0);
      chk("t4_dv_at_redir", bus.dec_valid, 1'b1);
      chk("t4_req_at_redir", bus.imem_req, 1'b0);
      step(1, 1, 0, 0, 0);
      chk("t4_dv_after", bus.dec_valid, 1'b0);
      chk("t4_req_after", bus.imem_req, 1'b1);
      chk("t4_addr_after", bus.imem_addr, 32'h0000_2000);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("t4_first_pc", bus.dec_pc, 32'h0000_2000);

      // PC wrap, then asynchronous reset mid-stream.
      step(1, 1, 1, 32'hFFFF_FFFE, 0);
      step(1, 1, 0, 0, 0);
      chk("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      step(1, 1, 0, 0, 0);
      chk("t5_addr_wrap", bus.imem_addr, 32'h0);
      step(1, 1, 0, 0, 0);
      chk("t5_pc_top", bus.dec_pc, 32'hFFFF_FFFC);
      step(1, 1, 0, 0, 0);
      chk("t5_pc_wrap", bus.dec_pc, 32'h0);
      @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("t5_async");
      do_reset();
      step(1, 1, 0, 0, 0);
      chk("t5_restart_req", bus.imem_req, 1'b1);
      chk("t5_restart_addr", bus.imem_addr, RPC);

`ifdef FETCH_PERF_EN
      do_reset();
      for (int k = 0; k < 3; k++) step(1, 1, 1, 32'h0000_0040, 0);
      n = 0;
      while (pops < 10 && n < 60) begin step(1, 1, 0, 0, 0); n++; end
      step(1, 0, 0, 0, 0);
      chk("t6_perf_fetched", perf_fetched, 32'd10);
      chk("t6_perf_redirects", perf_redirects, 32'd3);
`endif

      // Randomised traffic.
      lat_min = 1; lat_max = 4;
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         drdy  = ($urandom_range(0, 9) < 7);
         redir = ($urandom_range(0, 24) == 0);
         junk  = ($urandom_range(0, 19) == 0);
         rpc   = $urandom;
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         step(rdy, drdy, redir, rpc, junk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
